// File: rtl/cpu_host_pkg.sv
// cpu_host_pkg: opcodes, controller states and default memory depth shared by the host controller.
package cpu_host_pkg;
    localparam int DEF_MEM_DEPTH = 8;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;
    typedef enum logic [2:0] {IDLE, LD_CNT, LD_DATA, ST_CNT, STEPPING} state_t;
endpackage

// File: rtl/cpu_host_stepper.sv
// cpu_host_stepper: K-cycle down-counter; busy is high for exactly K cycles after load.
module cpu_host_stepper #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STEP_W-1:0] k,
    output logic              busy,
    output logic              last
);
    logic [STEP_W-1:0] cnt;
    assign last = busy && cnt == STEP_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= k;
            busy <= k != '0;
        end else if (busy) begin
            cnt  <= cnt - 1'b1;
            busy <= !last;
        end
    end
endmodule

// File: rtl/cpu_host_ctrl.sv
// cpu_host_ctrl: byte-command host controller sequencing CPU program load, run, halt and bounded step.
module cpu_host_ctrl
    import cpu_host_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_W    = 4,
    parameter int STEP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    output logic              cpu_ena,
    output logic              cpu_load,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_wdata,
    output logic              run_active,
    output logic              step_busy,
    output logic              err,
    output logic [7:0]        checksum
);
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [8:0] NMAX = 9'(MEM_DEPTH);
    state_t state;
    logic [7:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic xfer, step_load, step_last;
    assign xfer = host_valid && host_ready;
    assign step_load = state == ST_CNT && xfer && host_data != 8'd0;
    assign cpu_ena = run_active | step_busy | cpu_load;
    cpu_host_stepper #(.STEP_W(STEP_W)) u_stepper (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (step_load),
        .k     (STEP_W'(host_data)),
        .busy  (step_busy),
        .last  (step_last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            host_ready <= 1'b0;
            cpu_load   <= 1'b0;
            cpu_addr   <= '0;
            cpu_wdata  <= '0;
            run_active <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
            cnt        <= '0;
            addr       <= '0;
        end else begin
            cpu_load   <= 1'b0;
            host_ready <= 1'b1;
            case (state)
                IDLE: if (xfer) begin
                    err        <= 1'b0;
                    run_active <= host_data[7:6] == OP_RUN;
                    if (host_data[7:6] == OP_LOAD) begin
                        state    <= LD_CNT;
                        checksum <= '0;
                        addr     <= host_data[ADDR_W-1:0] & AMASK;
                    end else if (host_data[7:6] == OP_STEP) begin
                        state <= ST_CNT;
                    end
                end
                LD_CNT: if (xfer) begin
                    if (host_data == 8'd0 || {1'b0, host_data} > NMAX) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt   <= host_data;
                        state <= LD_DATA;
                    end
                end
                LD_DATA: if (xfer) begin
                    cpu_load  <= 1'b1;
                    cpu_addr  <= addr;
                    cpu_wdata <= host_data;
                    checksum  <= checksum + host_data;
                    addr      <= (addr + 1'b1) & AMASK;
                    cnt       <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= IDLE;
                end
                ST_CNT: if (xfer) begin
                    state      <= host_data != 8'd0 ? STEPPING : IDLE;
                    host_ready <= host_data == 8'd0;
                end
                STEPPING: begin
                    host_ready <= step_last;
                    if (step_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
